dmem_bridge: RTL

- Data-memory bus bridge between the single-cycle CPU's data port (addr, wdata, DM_R, DM_W) and a variable-latency synchronous data memory with a req/gnt/rvalid handshake.
- Converts each CPU load/store into one bus transaction and asserts a stall that freezes PC and register-file writeback until the access completes.
- Flags misaligned, illegal and timed-out accesses.

---
 rtl/dmem_bridge.sv | 117 +++++++++++
 1 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: CPU data port to req/gnt/rvalid memory bridge with stall, error and timeout handling.
// Define DMEM_BRIDGE_MMIO_EN to decode 0xFFFFxxxx locally (GPIO register and cycle counter).
module dmem_bridge #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] gpio_out,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t r_state, w_next;
   logic r_req, r_we, r_err;
   logic [29:0] r_addr;
   logic [31:0] r_wdata, r_rdata;
   logic [TO_W-1:0] r_cnt;
   logic w_acc, w_mis, w_bad, w_mmio, w_busy, w_ok, w_rcap, w_to;
   assign w_acc  = cpu_rd | cpu_wr;
   assign w_mis  = cpu_addr[1:0] != 2'b00;
   assign w_bad  = w_mis | (cpu_rd & cpu_wr);
   assign w_busy = (r_state == REQ) | (r_state == WAIT);
   assign w_rcap = mem_rvalid & ((r_state == WAIT) | ((r_state == REQ) & mem_gnt & ~r_we));
   assign w_ok   = w_rcap | ((r_state == REQ) & mem_gnt & r_we);
   // Abort on the 255th busy cycle unless the access completes in that same cycle
   assign w_to   = w_busy & ~w_ok & (r_cnt == TO_W'(TIMEOUT - 1));
`ifdef DMEM_BRIDGE_MMIO_EN
   logic [31:0] r_gpio, r_cyc;
   assign w_mmio   = cpu_addr[31:16] == 16'hFFFF;
   assign gpio_out = r_gpio;
`else
   assign w_mmio   = 1'b0;
   assign gpio_out = 32'd0;
`endif
   assign cpu_stall = w_acc & (r_state != DONE);
   assign cpu_rdata = r_rdata;
   assign mem_req   = r_req;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign err       = r_err;
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = !w_acc ? IDLE : (w_bad | w_mmio) ? DONE : REQ;
         REQ:     w_next = (w_ok | w_to) ? DONE : mem_gnt ? WAIT : REQ;
         WAIT:    w_next = (w_ok | w_to) ? DONE : WAIT;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (r_state == IDLE && w_acc) begin
            if (w_bad) begin
               r_err <= 1'b1;
               if (w_mis) r_rdata <= 32'd0;
            end else if (!w_mmio) begin
               r_req   <= 1'b1;
               r_we    <= cpu_wr;
               r_addr  <= cpu_addr[31:2];
               r_wdata <= cpu_wdata;
               r_cnt   <= '0;
            end
         end
         if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_rcap) r_rdata <= mem_rdata;
            if (w_to) begin
               r_err   <= 1'b1;
               r_rdata <= 32'hDEADBEEF;
            end
            if (w_next != r_state) begin
               r_req <= 1'b0;
               r_we  <= 1'b0;
            end
         end
`ifdef DMEM_BRIDGE_MMIO_EN
         if (r_state == IDLE && w_acc && !w_bad && w_mmio && cpu_rd)
            r_rdata <= (cpu_addr[15:0] == 16'h0000) ? r_gpio :
                       (cpu_addr[15:0] == 16'h0004) ? r_cyc : 32'd0;
`endif
      end
`ifdef DMEM_BRIDGE_MMIO_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_gpio <= '0;
         r_cyc  <= '0;
      end else begin
         r_cyc <= r_cyc + 1'b1;
         if (r_state == IDLE && cpu_wr && !w_bad && w_mmio && cpu_addr[15:0] == 16'h0000) r_gpio <= cpu_wdata;
      end
`endif
endmodule
